// File: rtl/div_unit_if.sv
// Operand/result bundle between the control unit and the multicycle divider.
// master = control unit (drives operands and Start), slave = div_unit.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output Start, Signed, A, B,
    input  Hi, Lo, Busy, Done, DivZero
  );

  modport slave (
    input  Start, Signed, A, B,
    output Hi, Lo, Busy, Done, DivZero
  );
endinterface

// File: rtl/div_unit.sv
// Restoring DIV/DIVU unit: Lo = quotient, Hi = remainder (sign of dividend); DIV_EARLY_EXIT_EN skips RUN when |A| < |B|.
// Latency: Done in the cycle after edge WIDTH+1 from Start (divide-by-zero and early exit go straight to DONE/FIX).
// Backpressure: none; Start is accepted only in IDLE, ignored while Busy, and Done is a single-cycle pulse.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  div_unit_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             short_op;
  logic             last_iter;
  logic [WIDTH:0]   shift;
  logic [WIDTH:0]   diff;
  logic             fits;

  // Two's-complement magnitude of the most negative value is itself, which is
  // exactly the right unsigned magnitude.
  assign a_neg  = bus.Signed & bus.A[WIDTH-1];
  assign b_neg  = bus.Signed & bus.B[WIDTH-1];
  assign a_mag  = a_neg ? -bus.A : bus.A;
  assign b_mag  = b_neg ? -bus.B : bus.B;
  assign b_zero = (bus.B == '0);

`ifdef DIV_EARLY_EXIT_EN
  assign short_op = (a_mag < b_mag);
`else
  assign short_op = 1'b0;
`endif

  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign shift     = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign diff      = shift - {1'b0, dvsr};
  assign fits      = (shift >= {1'b0, dvsr});

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.Busy  = 1'b1;
    bus.Done  = 1'b0;
    case (state)
      IDLE: begin
        bus.Busy = 1'b0;
        if (bus.Start) begin
          if (b_zero)        state_nxt = DONE;
          else if (short_op) state_nxt = FIX;
          else               state_nxt = RUN;
        end
      end
      RUN:  if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        bus.Done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            if (b_zero) begin
              div_zero <= 1'b1;
            end else begin
              div_zero <= 1'b0;
              dvsr     <= b_mag;
              q_neg    <= a_neg ^ b_neg;
              r_neg    <= a_neg;
              cnt      <= '0;
              if (short_op) begin
                quo <= '0;
                rem <= {1'b0, a_mag};
              end else begin
                quo <= a_mag;
                rem <= '0;
              end
            end
          end
        end
        // One restoring step per cycle; the extra rem bit keeps the shifted-out carry.
        RUN: begin
          rem <= fits ? diff : shift;
          quo <= {quo[WIDTH-2:0], fits};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          lo <= q_neg ? -quo : quo;
          hi <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.Hi      = hi;
  assign bus.Lo      = lo;
  assign bus.DivZero = div_zero;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes model results, negedge monitor pops on Done.
module tb_div_unit;
  localparam int W = 32;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  div_unit_if #(.WIDTH(W)) bus();
  div_unit #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          start;
    int          lat;
    bit          exact;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          chk_busy = 1'b0;
  exp_t        mon_e;
  int          mon_lat;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: compare every Done against the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (chk_busy) begin
      chk("busy_after_done", 32'(bus.Busy), 32'd0);
      chk_busy = 1'b0;
    end
    if (bus.Done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 want no Done (cycle %0d)", cyc);
      end else begin
        mon_e   = sb_q.pop_front();
        mon_lat = cyc - mon_e.start;
        chk("lo", bus.Lo, mon_e.lo);
        chk("hi", bus.Hi, mon_e.hi);
        chk("divzero", 32'(bus.DivZero), 32'(mon_e.dz));
        if (mon_e.exact) begin
          chk("latency", 32'(mon_lat), 32'(mon_e.lat));
        end else begin
          checks++;
          if (mon_lat > mon_e.lat) begin
            errors++;
            $display("FAIL short_latency: got %0d want <= %0d", mon_lat, mon_e.lat);
          end
        end
        chk_busy = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.Busy !== 1'b0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (bus.Busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got Busy=%b want 0 within 100 cycles", bus.Busy);
    end
  endtask

  // Reference: plain integer division; longint avoids the -2^31 / -1 overflow.
  task automatic do_op(input bit sg, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sbv, qq, rr;
    logic [31:0] am, bm;
    @(negedge Clk);
    wait_idle();
    bus.Start  = 1'b1;
    bus.Signed = sg;
    bus.A      = a;
    bus.B      = b;
    e.exact = 1'b1;
    e.lat   = 33;
    if (b == 32'd0) begin
      e.dz    = 1'b1;
      e.hi    = m_hi;
      e.lo    = m_lo;
      e.exact = 1'b0;
      e.lat   = 1;
    end else begin
      e.dz = 1'b0;
      if (sg) begin
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        qq   = sa / sbv;
        rr   = sa % sbv;
        e.lo = 32'(qq);
        e.hi = 32'(rr);
      end else begin
        e.lo = a / b;
        e.hi = a % b;
      end
      am = (sg && a[31]) ? -a : a;
      bm = (sg && b[31]) ? -b : b;
`ifdef DIV_EARLY_EXIT_EN
      if (am < bm) begin
        e.exact = 1'b0;
        e.lat   = 2;
      end
`else
      if (am < bm) e.lat = 33;
`endif
    end
    m_hi = e.hi;
    m_lo = e.lo;
    @(posedge Clk);
    #1;
    e.start = cyc;
    sb_q.push_back(e);
    @(negedge Clk);
    bus.Start  = 1'b0;
    bus.A      = $urandom;
    bus.B      = $urandom;
    bus.Signed = 1'($urandom_range(0, 1));
    chk("busy_running", 32'(bus.Busy), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs;
    int          n;
    bus.Start  = 1'b0;
    bus.Signed = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_hi", bus.Hi, 32'd0);
    chk("rst_lo", bus.Lo, 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_divzero", 32'(bus.DivZero), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    do_op(1'b0, 32'd100, 32'd7);
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    do_op(1'b1, 32'd100, 32'hFFFF_FFF9);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b0, 32'd100, 32'd7);
    do_op(1'b0, 32'd5, 32'd0);
    do_op(1'b1, 32'hFFFF_FFFF, 32'd0);
    do_op(1'b0, 32'd3, 32'd10);
    do_op(1'b1, 32'hFFFF_FFFD, 32'd10);

    // Start pulse in mid-run must be ignored.
    do_op(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge Clk);
    bus.Start = 1'b1;
    bus.A     = 32'd1;
    bus.B     = 32'd1;
    @(negedge Clk);
    bus.Start = 1'b0;

    // Reset in mid-run aborts with no Done and clears Hi/Lo.
    @(negedge Clk);
    wait_idle();
    bus.Start  = 1'b1;
    bus.Signed = 1'b0;
    bus.A      = 32'd200;
    bus.B      = 32'd9;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (14) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    chk("midrst_hi", bus.Hi, 32'd0);
    chk("midrst_lo", bus.Lo, 32'd0);
    chk("midrst_done", 32'(bus.Done), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    repeat (40) @(negedge Clk);

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: rb = 32'd0;
        2: rb = 32'($urandom_range(1, 16));
        default: begin
          rb = 32'($urandom_range(1000, 100000));
          ra = 32'($urandom_range(0, 999));
        end
      endcase
      do_op(rs, ra, rb);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb_q.size());
    end
    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
